// File: rtl/wb_seg7_scanner.sv
// wb_seg7_scanner: Wishbone classic slave holding display data and control for a
// multiplexed 7-segment array. One digit is lit per scan slot; each slot begins with
// a short all-anodes-off gap so the previous digit's segments cannot ghost into the
// next one. Register map (word select = wb_adr_i[3:2]):
//   0x0 DATA   : digit i = DATA[4i+3:4i]
//   0x4 CTRL   : [0] EN, [15:8] DP mask, [23:16] BLANK mask
//   0x8 STATUS : [2:0] current digit index (read only)
//   0xC        : unmapped, reads 0
module wb_seg7_scanner #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GHOST_GAP  = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int               CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(GHOST_GAP);
  localparam logic [2:0]       IDX_LAST  = 3'(DIGITS - 1);
  localparam logic [31:0]      DATA_MASK = 32'((33'd1 << (4 * DIGITS)) - 33'd1);
  localparam logic [7:0]       DIG_MASK  = 8'((9'd1 << DIGITS) - 9'd1);
  localparam logic             OFF_LVL   = (ACTIVE_LOW != 0);

  localparam logic [1:0] W_DATA   = 2'd0;
  localparam logic [1:0] W_CTRL   = 2'd1;
  localparam logic [1:0] W_STATUS = 2'd2;

  // Hex digit to segment pattern, bit order gfedcba, 1 = segment lit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Byte-lane merge of a bus write into an existing 32-bit register image.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wr,
                                              input logic [3:0]  sel);
    logic [31:0] m;
    m = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) m[8*b +: 8] = wr[8*b +: 8];
    end
    return m;
  endfunction

  // Register file; bits beyond the configured digit count stay zero.
  logic [31:0]      data_r;
  logic             en_r;
  logic [7:0]       dp_r;
  logic [7:0]       blank_r;

  // Scan position.
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;

  // Bus decode.
  logic             req;
  logic [1:0]       word;
  logic [31:0]      rdata;
  logic             unused_adr;

  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign word       = wb_adr_i[3:2];
  assign unused_adr = ^wb_adr_i[1:0];

  // Read mux over the register map; unmapped words and absent bits read zero.
  always_comb begin
    rdata = 32'h0;
    case (word)
      W_DATA:   rdata = data_r;
      W_CTRL:   rdata = {8'h00, blank_r, dp_r, 7'h00, en_r};
      W_STATUS: rdata = {29'h0, idx};
      default:  rdata = 32'h0;
    endcase
  end

  // Single-cycle ack; the ack itself blocks acceptance so acks never run back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'h0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : 32'h0;
    end
  end

  // Byte-wise register writes, landing together with the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= 32'h0;
      en_r    <= 1'b0;
      dp_r    <= 8'h00;
      blank_r <= 8'h00;
    end else if (req && wb_we_i) begin
      case (word)
        W_DATA: data_r <= merge_bytes(data_r, wb_dat_i, wb_sel_i) & DATA_MASK;
        W_CTRL: begin
          if (wb_sel_i[0]) en_r    <= wb_dat_i[0];
          if (wb_sel_i[1]) dp_r    <= wb_dat_i[15:8] & DIG_MASK;
          if (wb_sel_i[2]) blank_r <= wb_dat_i[23:16] & DIG_MASK;
        end
        default: ;
      endcase
    end
  end

  // Free-running slot counter and digit index, independent of EN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // ---- p0: decode current scan position into active-high drive levels ----
  logic       an_on_p0;
  logic [3:0] digit_p0;
  logic [7:0] an_full_p0;
  logic [6:0] seg_p0;
  logic       dp_p0;

  // Anode lit only outside the ghost gap, when enabled and not blanked.
  always_comb begin
    an_on_p0   = en_r & ~blank_r[idx] & (cnt >= CNT_GAP);
    digit_p0   = data_r[{idx, 2'b00} +: 4];
    an_full_p0 = {7'h00, an_on_p0} << idx;
    seg_p0     = an_on_p0 ? hex7(digit_p0) : 7'h00;
    dp_p0      = an_on_p0 & dp_r[idx];
  end

  // ---- p1: registered pad drive with output polarity applied ----
  logic [6:0]        seg_p1;
  logic              dp_p1;
  logic [DIGITS-1:0] an_p1;

  // Output register; reset parks every pad at its off level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1 <= {7{OFF_LVL}};
      dp_p1  <= OFF_LVL;
      an_p1  <= {DIGITS{OFF_LVL}};
    end else begin
      seg_p1 <= seg_p0 ^ {7{OFF_LVL}};
      dp_p1  <= dp_p0 ^ OFF_LVL;
      an_p1  <= an_full_p0[DIGITS-1:0] ^ {DIGITS{OFF_LVL}};
    end
  end

  assign seg_o = seg_p1;
  assign dp_o  = dp_p1;
  assign an_o  = an_p1;

endmodule
